controller_r1: RTL and testbench

- Second-generation SIMD core controller.
- Decodes one vector instruction per cycle through a valid/ready handshake and issues one-cycle enable pulses to the functional units.
- Tracks busy time of the non-pipelined units (DIV, activation, transpose) and reserves the single register-file writeback port by latency slot.
- Drives writeback select and RegWrite when each result returns.
- Sits between the instruction buffer and the SIMD lane datapath.

---
 rtl/controller_r1.sv | 377 +++++++++++++++++++++++++++++++++++++
 tb/tb_controller_r1.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controller_r1.sv
// -----------------------------------------------------------------------------
// controller_r1 -- SIMD core controller, second generation.
//
// Accepts one vector instruction per cycle from the instruction buffer over a
// valid/ready handshake. It decodes the instruction and sends a one-cycle
// enable pulse to the selected functional unit. It also tracks the busy time
// of the non-pipelined units (DIV, activation, transpose). The single
// register-file writeback port is reserved by latency slot, so two results
// can never return in the same cycle.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      instruction handshake (in_ready is combinational)
//   opcode, funcode, dt      operation class, ALU sub-op, data type
//   acc, sat                 accumulate (FMA), saturate (integer ops)
//   INT_*_EN / FP16_*_EN     per-unit issue pulses, integer / FP16 variants
//   RELU_EN .. TR_EN_PULSE   type-agnostic issue pulses
//   ALUOp, IntSigned,        registered qualifiers that travel with the
//   Saturated, AccEn           issue pulse
//   PipeRegSel, RegWrite     one-hot writeback source select and strobe
//   illegal                  pulse for an accepted illegal instruction
//   busy                     any unit busy or any writeback outstanding
// -----------------------------------------------------------------------------
module controller_r1 #(
    parameter int NUM_FUNC  = 12,
    parameter int MUL_LAT   = 3,
    parameter int FMA_LAT   = 4,
    parameter int DIV_LAT   = 8,
    parameter int ACT_LAT   = 6,
    parameter int LD_LAT    = 2,
    parameter int TR_CYCLES = 4,
    parameter int MAX_LAT   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4:0]          opcode,
    input  logic [1:0]          funcode,
    input  logic [1:0]          dt,
    input  logic                acc,
    input  logic                sat,
    output logic                INT_ALU_EN,
    output logic                INT_MUL_EN,
    output logic                INT_DIV_EN,
    output logic                INT_FMA_EN,
    output logic                INT_SIGMA_EN,
    output logic                INT_TANH_EN,
    output logic                FP16_ALU_EN,
    output logic                FP16_MUL_EN,
    output logic                FP16_DIV_EN,
    output logic                FP16_FMA_EN,
    output logic                FP16_SIGMA_EN,
    output logic                FP16_TANH_EN,
    output logic                RELU_EN,
    output logic                LD_EN,
    output logic                ST_EN,
    output logic                BC_EN,
    output logic                TR_EN_PULSE,
    output logic [1:0]          ALUOp,
    output logic                IntSigned,
    output logic                Saturated,
    output logic                AccEn,
    output logic [NUM_FUNC-1:0] PipeRegSel,
    output logic                RegWrite,
    output logic                illegal,
    output logic                busy
);

    localparam int SRC_W = $clog2(NUM_FUNC);
    localparam int LAT_W = $clog2(MAX_LAT + 1);
    localparam int CNT_W = $clog2(DIV_LAT + ACT_LAT + TR_CYCLES + 1);
    localparam int NUM_EN = 17;

    // Opcode map
    localparam logic [4:0] OP_NOP   = 5'h00;
    localparam logic [4:0] OP_ALU   = 5'h01;
    localparam logic [4:0] OP_MUL   = 5'h02;
    localparam logic [4:0] OP_DIV   = 5'h03;
    localparam logic [4:0] OP_FMA   = 5'h04;
    localparam logic [4:0] OP_SIGMA = 5'h05;
    localparam logic [4:0] OP_TANH  = 5'h06;
    localparam logic [4:0] OP_RELU  = 5'h07;
    localparam logic [4:0] OP_LD    = 5'h08;
    localparam logic [4:0] OP_ST    = 5'h09;
    localparam logic [4:0] OP_BC    = 5'h0A;
    localparam logic [4:0] OP_TR    = 5'h0B;

    // Writeback source indices (bit positions in PipeRegSel)
    localparam logic [SRC_W-1:0] SRC_ALU  = SRC_W'(0);
    localparam logic [SRC_W-1:0] SRC_MUL  = SRC_W'(1);
    localparam logic [SRC_W-1:0] SRC_DIV  = SRC_W'(2);
    localparam logic [SRC_W-1:0] SRC_FMA  = SRC_W'(3);
    localparam logic [SRC_W-1:0] SRC_ACT  = SRC_W'(4);
    localparam logic [SRC_W-1:0] SRC_RELU = SRC_W'(5);
    localparam logic [SRC_W-1:0] SRC_LD   = SRC_W'(6);
    localparam logic [SRC_W-1:0] SRC_BC   = SRC_W'(7);

    // Bit positions in the internal issue-pulse vector. Each FP16 variant
    // sits six positions above its integer twin.
    localparam int E_INT_ALU   = 0;
    localparam int E_INT_MUL   = 1;
    localparam int E_INT_DIV   = 2;
    localparam int E_INT_FMA   = 3;
    localparam int E_INT_SIGMA = 4;
    localparam int E_INT_TANH  = 5;
    localparam int E_FP_ALU    = 6;
    localparam int E_FP_MUL    = 7;
    localparam int E_FP_DIV    = 8;
    localparam int E_FP_FMA    = 9;
    localparam int E_FP_SIGMA  = 10;
    localparam int E_FP_TANH   = 11;
    localparam int E_RELU      = 12;
    localparam int E_LD        = 13;
    localparam int E_ST        = 14;
    localparam int E_BC        = 15;
    localparam int E_TR        = 16;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]  div_cnt;
    logic [CNT_W-1:0]  act_cnt;
    logic [CNT_W-1:0]  tr_cnt;
    logic [MAX_LAT-1:0] res_valid;
    logic [SRC_W-1:0]  res_src [MAX_LAT];
    logic [NUM_EN-1:0] en_q;
    logic              illegal_q;
    logic [1:0]        alu_op_q;
    logic              int_signed_q;
    logic              sat_q;
    logic              acc_q;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic              known;
    logic              needs_dt;
    logic              has_wb;
    logic              is_div;
    logic              is_act;
    logic              is_tr;
    logic [LAT_W-1:0]  lat;
    logic [LAT_W-1:0]  wb_idx;
    logic [SRC_W-1:0]  src;
    logic [NUM_EN-1:0] en_sel;
    logic              illegal_op;
    logic              slot_taken;
    logic              stall;
    logic              accept;
    logic              issue;

    // NOTE: every signal written here gets a default value first. Without the
    // defaults, any case branch that skips a signal would infer a latch.
    always_comb begin
        known    = 1'b1;
        needs_dt = 1'b1;
        has_wb   = 1'b0;
        is_div   = 1'b0;
        is_act   = 1'b0;
        is_tr    = 1'b0;
        lat      = '0;
        src      = '0;
        en_sel   = '0;
        case (opcode)
            OP_NOP: needs_dt = 1'b0;
            OP_ALU: begin
                has_wb = 1'b1;
                lat    = LAT_W'(1);
                src    = SRC_ALU;
                en_sel[dt[1] ? E_FP_ALU : E_INT_ALU] = 1'b1;
            end
            OP_MUL: begin
                has_wb = 1'b1;
                lat    = LAT_W'(MUL_LAT);
                src    = SRC_MUL;
                en_sel[dt[1] ? E_FP_MUL : E_INT_MUL] = 1'b1;
            end
            OP_DIV: begin
                has_wb = 1'b1;
                is_div = 1'b1;
                lat    = LAT_W'(DIV_LAT);
                src    = SRC_DIV;
                en_sel[dt[1] ? E_FP_DIV : E_INT_DIV] = 1'b1;
            end
            OP_FMA: begin
                has_wb = 1'b1;
                lat    = LAT_W'(FMA_LAT);
                src    = SRC_FMA;
                en_sel[dt[1] ? E_FP_FMA : E_INT_FMA] = 1'b1;
            end
            OP_SIGMA: begin
                has_wb = 1'b1;
                is_act = 1'b1;
                lat    = LAT_W'(ACT_LAT);
                src    = SRC_ACT;
                en_sel[dt[1] ? E_FP_SIGMA : E_INT_SIGMA] = 1'b1;
            end
            OP_TANH: begin
                has_wb = 1'b1;
                is_act = 1'b1;
                lat    = LAT_W'(ACT_LAT);
                src    = SRC_ACT;
                en_sel[dt[1] ? E_FP_TANH : E_INT_TANH] = 1'b1;
            end
            OP_RELU: begin
                has_wb = 1'b1;
                lat    = LAT_W'(1);
                src    = SRC_RELU;
                en_sel[E_RELU] = 1'b1;
            end
            OP_LD: begin
                has_wb = 1'b1;
                lat    = LAT_W'(LD_LAT);
                src    = SRC_LD;
                en_sel[E_LD] = 1'b1;
            end
            OP_ST: begin
                needs_dt = 1'b0;
                en_sel[E_ST] = 1'b1;
            end
            OP_BC: begin
                has_wb = 1'b1;
                lat    = LAT_W'(1);
                src    = SRC_BC;
                en_sel[E_BC] = 1'b1;
            end
            OP_TR: begin
                needs_dt = 1'b0;
                is_tr    = 1'b1;
                en_sel[E_TR] = 1'b1;
            end
            default: known = 1'b0;
        endcase
    end

    assign illegal_op = !known
                      || (needs_dt && dt == 2'b11)
                      || (opcode == OP_RELU && dt[1]);

    // The new entry lands in index lat-1 after this cycle's shift, which is
    // the entry currently held at index lat. A latency of MAX_LAT targets
    // the top entry, which is always empty after a shift, so it never clashes.
    always_comb begin
        slot_taken = 1'b0;
        for (int i = 1; i < MAX_LAT; i++) begin
            if (has_wb && lat == LAT_W'(i)) begin
                slot_taken = res_valid[i];
            end
        end
    end

    // A counter at 1 reaches 0 at the end of this cycle, so the unit is
    // already free for a new instruction. That gives an issue spacing of
    // exactly *_LAT / TR_CYCLES.
    assign stall = !illegal_op && ((is_div && div_cnt > CNT_W'(1))
                                || (is_act && act_cnt > CNT_W'(1))
                                || (is_tr  && tr_cnt  > CNT_W'(1))
                                || slot_taken);

    assign in_ready = !rst && !stall;
    assign accept   = in_valid && in_ready;
    assign issue    = accept && !illegal_op;
    assign wb_idx   = lat - LAT_W'(1);

    // ------------------------------------------------------------------
    // Issue pulses and qualifiers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then samples the pre-edge values, whatever the block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q         <= '0;
            illegal_q    <= 1'b0;
            alu_op_q     <= 2'b00;
            int_signed_q <= 1'b0;
            sat_q        <= 1'b0;
            acc_q        <= 1'b0;
        end else begin
            en_q      <= issue ? en_sel : '0;
            illegal_q <= accept && illegal_op;
            if (issue) begin
                alu_op_q     <= funcode;
                int_signed_q <= (dt == 2'b00);
                sat_q        <= sat && !dt[1];
                acc_q        <= acc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Busy counters for the non-pipelined units
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            act_cnt <= '0;
            tr_cnt  <= '0;
        end else begin
            if (issue && is_div)       div_cnt <= CNT_W'(DIV_LAT);
            else if (div_cnt != '0)    div_cnt <= div_cnt - CNT_W'(1);

            if (issue && is_act)       act_cnt <= CNT_W'(ACT_LAT);
            else if (act_cnt != '0)    act_cnt <= act_cnt - CNT_W'(1);

            if (issue && is_tr)        tr_cnt  <= CNT_W'(TR_CYCLES);
            else if (tr_cnt != '0)     tr_cnt  <= tr_cnt - CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Writeback reservation register. It shifts down one entry per cycle,
    // and entry 0 is the result returning this cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= '0;
        end else begin
            res_valid <= res_valid >> 1;
            if (issue && has_wb) begin
                for (int i = 0; i < MAX_LAT; i++) begin
                    if (wb_idx == LAT_W'(i)) res_valid[i] <= 1'b1;
                end
            end
        end
    end

    // NOTE: the source tags are deliberately left out of reset. A tag is only
    // read while its valid bit is set, and the valid bits are reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < MAX_LAT - 1; i++) begin
            res_src[i] <= res_src[i+1];
        end
        if (issue && has_wb) begin
            for (int i = 0; i < MAX_LAT; i++) begin
                if (wb_idx == LAT_W'(i)) res_src[i] <= src;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        PipeRegSel = '0;
        if (res_valid[0]) PipeRegSel[res_src[0]] = 1'b1;
    end

    assign RegWrite = res_valid[0];
    assign busy     = (div_cnt != '0) || (act_cnt != '0) || (tr_cnt != '0)
                   || (res_valid != '0);

    assign INT_ALU_EN    = en_q[E_INT_ALU];
    assign INT_MUL_EN    = en_q[E_INT_MUL];
    assign INT_DIV_EN    = en_q[E_INT_DIV];
    assign INT_FMA_EN    = en_q[E_INT_FMA];
    assign INT_SIGMA_EN  = en_q[E_INT_SIGMA];
    assign INT_TANH_EN   = en_q[E_INT_TANH];
    assign FP16_ALU_EN   = en_q[E_FP_ALU];
    assign FP16_MUL_EN   = en_q[E_FP_MUL];
    assign FP16_DIV_EN   = en_q[E_FP_DIV];
    assign FP16_FMA_EN   = en_q[E_FP_FMA];
    assign FP16_SIGMA_EN = en_q[E_FP_SIGMA];
    assign FP16_TANH_EN  = en_q[E_FP_TANH];
    assign RELU_EN       = en_q[E_RELU];
    assign LD_EN         = en_q[E_LD];
    assign ST_EN         = en_q[E_ST];
    assign BC_EN         = en_q[E_BC];
    assign TR_EN_PULSE   = en_q[E_TR];

    assign ALUOp     = alu_op_q;
    assign IntSigned = int_signed_q;
    assign Saturated = sat_q;
    assign AccEn     = acc_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_controller_r1.sv
// -----------------------------------------------------------------------------
// tb_controller_r1 -- scoreboard bench for controller_r1.
//
// The driver presents directed instructions, each with a hand-written
// expected enable mask, latency and source. On acceptance it queues the
// expected issue event (cycle t+1) and writeback event (cycle t+L). Two
// monitors pop and compare whenever the DUT shows an issue/illegal pulse or
// a writeback. Handshake timing is checked directly in the stimulus flow.
// -----------------------------------------------------------------------------
module tb_controller_r1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  opcode = 5'h00;
    logic [1:0]  funcode = 2'b00;
    logic [1:0]  dt = 2'b00;
    logic        acc = 1'b0;
    logic        sat = 1'b0;
    logic        INT_ALU_EN, INT_MUL_EN, INT_DIV_EN, INT_FMA_EN, INT_SIGMA_EN, INT_TANH_EN;
    logic        FP16_ALU_EN, FP16_MUL_EN, FP16_DIV_EN, FP16_FMA_EN, FP16_SIGMA_EN, FP16_TANH_EN;
    logic        RELU_EN, LD_EN, ST_EN, BC_EN, TR_EN_PULSE;
    logic [1:0]  ALUOp;
    logic        IntSigned, Saturated, AccEn;
    logic [11:0] PipeRegSel;
    logic        RegWrite, illegal, busy;

    controller_r1 dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funcode(funcode), .dt(dt), .acc(acc), .sat(sat),
        .INT_ALU_EN(INT_ALU_EN), .INT_MUL_EN(INT_MUL_EN), .INT_DIV_EN(INT_DIV_EN),
        .INT_FMA_EN(INT_FMA_EN), .INT_SIGMA_EN(INT_SIGMA_EN), .INT_TANH_EN(INT_TANH_EN),
        .FP16_ALU_EN(FP16_ALU_EN), .FP16_MUL_EN(FP16_MUL_EN), .FP16_DIV_EN(FP16_DIV_EN),
        .FP16_FMA_EN(FP16_FMA_EN), .FP16_SIGMA_EN(FP16_SIGMA_EN), .FP16_TANH_EN(FP16_TANH_EN),
        .RELU_EN(RELU_EN), .LD_EN(LD_EN), .ST_EN(ST_EN), .BC_EN(BC_EN),
        .TR_EN_PULSE(TR_EN_PULSE), .ALUOp(ALUOp), .IntSigned(IntSigned),
        .Saturated(Saturated), .AccEn(AccEn), .PipeRegSel(PipeRegSel),
        .RegWrite(RegWrite), .illegal(illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected enable masks, bit 0 = INT_ALU_EN ... bit 16 = TR_EN_PULSE
    localparam logic [16:0] X_NONE      = 17'h00000;
    localparam logic [16:0] X_INT_ALU   = 17'h00001;
    localparam logic [16:0] X_INT_MUL   = 17'h00002;
    localparam logic [16:0] X_INT_DIV   = 17'h00004;
    localparam logic [16:0] X_INT_FMA   = 17'h00008;
    localparam logic [16:0] X_INT_TANH  = 17'h00020;
    localparam logic [16:0] X_FP_ALU    = 17'h00040;
    localparam logic [16:0] X_FP_MUL    = 17'h00080;
    localparam logic [16:0] X_FP_FMA    = 17'h00200;
    localparam logic [16:0] X_FP_SIGMA  = 17'h00400;
    localparam logic [16:0] X_RELU      = 17'h01000;
    localparam logic [16:0] X_LD        = 17'h02000;
    localparam logic [16:0] X_ST        = 17'h04000;
    localparam logic [16:0] X_BC        = 17'h08000;
    localparam logic [16:0] X_TR        = 17'h10000;
    localparam logic [16:0] X_ANY_ALU   = 17'h00041;
    localparam logic [16:0] X_ANY_FMA   = 17'h00208;

    logic [16:0] act_en;
    assign act_en = {TR_EN_PULSE, BC_EN, ST_EN, LD_EN, RELU_EN,
                     FP16_TANH_EN, FP16_SIGMA_EN, FP16_FMA_EN, FP16_DIV_EN, FP16_MUL_EN, FP16_ALU_EN,
                     INT_TANH_EN, INT_SIGMA_EN, INT_FMA_EN, INT_DIV_EN, INT_MUL_EN, INT_ALU_EN};

    typedef struct {
        int          cyc;
        logic [16:0] en;
        logic        ill;
        logic [1:0]  aluop;
        logic        ints;
        logic        satd;
        logic        accen;
    } iss_t;

    typedef struct {
        int          cyc;
        logic [11:0] sel;
    } wb_t;

    iss_t iss_q[$];
    wb_t  wb_q[$];
    iss_t ie;
    wb_t  we;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Keep the writeback queue ordered by return cycle.
    task automatic push_wb(input int c, input logic [11:0] sel);
        wb_t w;
        int  pos;
        w.cyc = c;
        w.sel = sel;
        pos = wb_q.size();
        for (int i = 0; i < wb_q.size(); i++) begin
            if (wb_q[i].cyc > c) begin
                pos = i;
                break;
            end
        end
        wb_q.insert(pos, w);
    endtask

    // Starts and ends 1 time unit after a rising edge. tacc is the cycle in
    // which the handshake completed, or -1 on timeout.
    task automatic send(input logic [4:0] op, input logic [1:0] fn, input logic [1:0] d,
                        input logic a, input logic s, input logic [16:0] xen, input logic xill,
                        input int xlat, input int xsrc, output int tacc);
        iss_t e;
        opcode   = op;
        funcode  = fn;
        dt       = d;
        acc      = a;
        sat      = s;
        in_valid = 1'b1;
        tacc     = -1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (in_ready) begin
                tacc = cyc;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (tacc < 0) begin
            check("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
        end else begin
            if (xen != X_NONE || xill) begin
                e.cyc   = tacc + 1;
                e.en    = xen;
                e.ill   = xill;
                e.aluop = fn;
                e.ints  = (d == 2'b00);
                e.satd  = s & ~d[1];
                e.accen = a;
                iss_q.push_back(e);
            end
            if (xlat > 0) push_wb(tacc + xlat, 12'(1) << xsrc);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!busy && iss_q.size() == 0 && wb_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check("drain_timeout", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Issue/illegal monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (act_en != X_NONE || illegal) begin
                if (iss_q.size() == 0) begin
                    check("issue_unexpected", {14'd0, illegal, act_en}, 32'd0);
                end else begin
                    ie = iss_q.pop_front();
                    check("issue_cycle", cyc, ie.cyc);
                    check("issue_en", {15'd0, act_en}, {15'd0, ie.en});
                    check("issue_illegal", {31'd0, illegal}, {31'd0, ie.ill});
                    if (ie.en != X_NONE) begin
                        check("IntSigned", {31'd0, IntSigned}, {31'd0, ie.ints});
                        check("Saturated", {31'd0, Saturated}, {31'd0, ie.satd});
                        if ((ie.en & X_ANY_ALU) != X_NONE)
                            check("ALUOp", {30'd0, ALUOp}, {30'd0, ie.aluop});
                        if ((ie.en & X_ANY_FMA) != X_NONE)
                            check("AccEn", {31'd0, AccEn}, {31'd0, ie.accen});
                    end
                end
            end else if (iss_q.size() != 0 && iss_q[0].cyc <= cyc) begin
                ie = iss_q.pop_front();
                check("issue_missing", {14'd0, illegal, act_en}, {14'd0, ie.ill, ie.en});
            end
        end
    end

    // Writeback monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (RegWrite || PipeRegSel != 12'd0) begin
                if (wb_q.size() == 0) begin
                    check("wb_unexpected", {19'd0, RegWrite, PipeRegSel}, 32'd0);
                end else begin
                    we = wb_q.pop_front();
                    check("wb_cycle", cyc, we.cyc);
                    check("wb_sel", {20'd0, PipeRegSel}, {20'd0, we.sel});
                    check("wb_regwrite", {31'd0, RegWrite}, 32'd1);
                end
            end else if (wb_q.size() != 0 && wb_q[0].cyc <= cyc) begin
                we = wb_q.pop_front();
                check("wb_missing", {20'd0, PipeRegSel}, {20'd0, we.sel});
            end
        end
    end

    initial begin
        int t1, t2;

        // Reset: in_ready must stay low even with a valid ALU presented.
        rst      = 1'b1;
        in_valid = 1'b1;
        opcode   = 5'h01;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        rst      = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_regwrite", {19'd0, RegWrite, PipeRegSel}, 32'd0);
        check("rst_pulses", {14'd0, illegal, act_en}, 32'd0);

        // Back-to-back ALU (int signed, funcode 2) and FP16 MUL.
        send(5'h01, 2'd2, 2'b00, 1'b0, 1'b0, X_INT_ALU, 1'b0, 1, 0, t1);
        send(5'h02, 2'd0, 2'b10, 1'b0, 1'b0, X_FP_MUL,  1'b0, 3, 1, t2);
        check("alu_mul_back_to_back", t2, t1 + 1);
        wait_idle();

        // DIV then DIV: the second one waits exactly DIV_LAT cycles.
        send(5'h03, 2'd0, 2'b01, 1'b0, 1'b0, X_INT_DIV, 1'b0, 8, 2, t1);
        send(5'h03, 2'd0, 2'b01, 1'b0, 1'b0, X_INT_DIV, 1'b0, 8, 2, t2);
        check("div_spacing", t2 - t1, 32'd8);
        check("div_busy", {31'd0, busy}, 32'd1);
        wait_idle();

        // Writeback collision: LD presented two cycles after FMA slips one.
        send(5'h04, 2'd0, 2'b10, 1'b1, 1'b0, X_FP_FMA, 1'b0, 4, 3, t1);
        idle(1);
        send(5'h08, 2'd0, 2'b00, 1'b0, 1'b0, X_LD, 1'b0, 2, 6, t2);
        check("ld_collision_stall", t2 - t1, 32'd3);
        wait_idle();

        // Illegal opcode and FP16 RELU: illegal pulses only, busy stays low.
        send(5'h1F, 2'd0, 2'b00, 1'b0, 1'b0, X_NONE, 1'b1, 0, 0, t1);
        check("illegal_busy_a", {31'd0, busy}, 32'd0);
        send(5'h07, 2'd0, 2'b10, 1'b0, 1'b0, X_NONE, 1'b1, 0, 0, t2);
        check("illegal_back_to_back", t2, t1 + 1);
        @(negedge clk);
        check("illegal_busy_b", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        wait_idle();

        // TR then TR: spaced by TR_CYCLES, no writeback.
        send(5'h0B, 2'd0, 2'b11, 1'b0, 1'b0, X_TR, 1'b0, 0, 0, t1);
        send(5'h0B, 2'd0, 2'b11, 1'b0, 1'b0, X_TR, 1'b0, 0, 0, t2);
        check("tr_spacing", t2 - t1, 32'd4);
        wait_idle();

        // Mixed directed vectors, including the activation-unit spacing.
        send(5'h01, 2'd1, 2'b10, 1'b0, 1'b0, X_FP_ALU,   1'b0, 1, 0, t1);
        send(5'h02, 2'd0, 2'b00, 1'b0, 1'b1, X_INT_MUL,  1'b0, 3, 1, t1);
        send(5'h04, 2'd0, 2'b01, 1'b1, 1'b1, X_INT_FMA,  1'b0, 4, 3, t1);
        send(5'h05, 2'd0, 2'b10, 1'b0, 1'b0, X_FP_SIGMA, 1'b0, 6, 4, t1);
        send(5'h06, 2'd0, 2'b00, 1'b0, 1'b0, X_INT_TANH, 1'b0, 6, 4, t2);
        check("act_spacing", t2 - t1, 32'd6);
        send(5'h07, 2'd0, 2'b01, 1'b0, 1'b1, X_RELU,     1'b0, 1, 5, t1);
        send(5'h09, 2'd0, 2'b11, 1'b0, 1'b0, X_ST,       1'b0, 0, 0, t1);
        send(5'h0A, 2'd0, 2'b10, 1'b0, 1'b0, X_BC,       1'b0, 1, 7, t1);
        send(5'h00, 2'd0, 2'b11, 1'b0, 1'b0, X_NONE,     1'b0, 0, 0, t1);
        send(5'h08, 2'd0, 2'b11, 1'b0, 1'b0, X_NONE,     1'b1, 0, 0, t1);
        send(5'h0C, 2'd0, 2'b00, 1'b0, 1'b0, X_NONE,     1'b1, 0, 0, t1);
        wait_idle();

        // Reset mid-DIV: writeback dropped, new DIV accepted right away.
        send(5'h03, 2'd0, 2'b10, 1'b0, 1'b0, 17'h00100, 1'b0, 8, 2, t1);
        idle(2);
        rst = 1'b1;
        wb_q.delete();
        iss_q.delete();
        #1;
        check("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_regwrite", {19'd0, RegWrite, PipeRegSel}, 32'd0);
        check("rst_mid_pulses", {14'd0, illegal, act_en}, 32'd0);
        t2 = cyc;
        send(5'h03, 2'd0, 2'b00, 1'b0, 1'b0, X_INT_DIV, 1'b0, 8, 2, t1);
        check("div_after_rst", t1, t2);
        check("div_after_rst_spacing", t1 - t2, 32'd0);
        wait_idle();
        idle(12);

        check("iss_q_empty", iss_q.size(), 32'd0);
        check("wb_q_empty", wb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
